// File: rtl/ps2_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_rx : PS/2 device-to-host receiver (sync, glitch filter, frame FSM).   |
// | Optional macro PS2_RX_PARITY_CHECK_EN drops bytes that fail odd parity.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK50M,
  input  logic       nRST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       valid_o,
  output logic [7:0] recv_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int c_tcnt_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_tcnt_w-1:0] c_tcnt_max = c_tcnt_w'(TIMEOUT_CYC - 1);
  localparam logic [7:0] c_flt_max = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic                r_filt, r_filt_d;
  logic [7:0]          r_fcnt;
  logic [c_tcnt_w-1:0] r_tcnt;
  logic [7:0]          r_shreg;
  logic [2:0]          r_bit_cnt;
  logic                r_par;
  logic                w_fall, w_timeout, w_par_bad;
  logic                w_valid, w_ferr, w_perr;

  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DATA;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered level only flips after FILTER_LEN consecutive opposing samples.
  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == c_flt_max) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end

  assign w_fall    = r_filt_d & ~r_filt;
  assign w_timeout = (r_state != IDLE) && (r_tcnt == c_tcnt_max);
  assign w_par_bad = ~(^{r_shreg, r_par});

  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) begin
      r_tcnt <= '0;
    end else if (w_fall) begin
      r_tcnt <= '0;
    end else if (r_tcnt != c_tcnt_max) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Timeout outranks a coincident fall; bad stop bit outranks parity.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_ferr      = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!r_dat_s2) w_state_nxt = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          if (!r_dat_s2) begin
            w_ferr = 1'b1;
          end else if (w_par_bad) begin
`ifdef PS2_RX_PARITY_CHECK_EN
            w_perr = 1'b1;
`else
            w_valid = 1'b1;
`endif
          end else begin
            w_valid = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else if (w_timeout) begin
      r_shreg <= '0;
    end else if (w_fall) begin
      case (r_state)
        IDLE:   r_bit_cnt <= '0;
        DATA: begin
          r_shreg   <= {r_dat_s2, r_shreg[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        PARITY: r_par <= r_dat_s2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) begin
      valid_o   <= 1'b0;
      frame_err <= 1'b0;
      recv_data <= '0;
    end else begin
      valid_o   <= w_valid;
      frame_err <= w_ferr;
      if (w_valid) recv_data <= r_shreg;
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  always_ff @(posedge CLK50M or negedge nRST) begin
    if (!nRST) parity_err <= 1'b0;
    else       parity_err <= w_perr;
  end
`else
  assign parity_err = 1'b0;
  logic w_unused;
  assign w_unused = w_perr;
`endif

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_rx : directed frame table plus glitch, timeout and reset sequences.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ps2_rx;

  logic       CLK50M;
  logic       nRST;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       valid_o;
  logic [7:0] recv_data;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  logic [2:0] cnt_pre, cnt_post;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(4500)) dut (
    .CLK50M    (CLK50M),
    .nRST      (nRST),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .valid_o   (valid_o),
    .recv_data (recv_data),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial CLK50M = 1'b0;
  always #10 CLK50M = ~CLK50M;

  always @(negedge CLK50M) begin
    if (valid_o)    n_valid++;
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         half;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_recv;
  } vec_t;

  vec_t vecs[8];

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK50M);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    @(posedge CLK50M);
    n_valid = 0;
    n_ferr  = 0;
    n_perr  = 0;
  endtask

  // bits[0] goes out first; optional 3-cycle clock glitch after bit glitch_at.
  task automatic drive(input logic [10:0] bits, input int nbits, input int half,
                       input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = bits[i];
      cyc(half);
      PS2_CLK = 1'b0;
      cyc(half);
      PS2_CLK = 1'b1;
      if (i == glitch_at) begin
        cyc(20);
        cnt_pre = dut.r_bit_cnt;
        PS2_CLK = 1'b0;
        cyc(3);
        PS2_CLK = 1'b1;
        cyc(20);
        cnt_post = dut.r_bit_cnt;
      end
    end
    PS2_DATA = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic wait_ferr(input string name);
    int k;
    k = 0;
    while (n_ferr == 0 && k < 7000) begin
      cyc(1);
      k++;
    end
    cyc(5);
    check({name, "_ferr"}, n_ferr, 1);
    check({name, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 2000, 1, 0, 0, 8'h1C};
`ifdef PS2_RX_PARITY_CHECK_EN
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 60, 0, 0, 1, 8'h1C};
`else
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 60, 1, 0, 0, 8'h1C};
`endif
    vecs[2] = '{8'hF0, 1'b1, 1'b0, 60, 0, 1, 0, 8'h1C};
    vecs[3] = '{8'h29, 1'b0, 1'b1, 60, 1, 0, 0, 8'h29};
`ifdef PS2_RX_PARITY_CHECK_EN
    vecs[4] = '{8'hA7, 1'b1, 1'b1, 60, 0, 0, 1, 8'h29};
`else
    vecs[4] = '{8'hA7, 1'b1, 1'b1, 60, 1, 0, 0, 8'hA7};
`endif
    vecs[5] = '{8'h00, 1'b1, 1'b1, 60, 1, 0, 0, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 60, 1, 0, 0, 8'hFF};
    vecs[7] = '{8'hF0, 1'b0, 1'b0, 60, 0, 1, 0, 8'hFF};

    nRST = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    cyc(3);
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_recv", {24'd0, recv_data}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_perr", {31'd0, parity_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    nRST = 1'b1;
    cyc(20);

    for (int v = 0; v < 8; v++) begin
      clr_counts();
      drive(frame(vecs[v].data, vecs[v].par, vecs[v].stop), 11, vecs[v].half, -1);
      cyc(20);
      check($sformatf("v%0d_valid", v), n_valid, vecs[v].exp_valid);
      check($sformatf("v%0d_ferr", v), n_ferr, vecs[v].exp_ferr);
      check($sformatf("v%0d_perr", v), n_perr, vecs[v].exp_perr);
      check($sformatf("v%0d_recv", v), {24'd0, recv_data}, {24'd0, vecs[v].exp_recv});
      check($sformatf("v%0d_busy", v), {31'd0, busy}, 0);
    end

    // Timeout after start + 4 data bits, then a clean frame.
    clr_counts();
    drive(frame(8'hC3, 1'b1, 1'b1), 5, 60, -1);
    cyc(1000);
    check("to_busy_mid", {31'd0, busy}, 1);
    check("to_ferr_early", n_ferr, 0);
    wait_ferr("to");
    check("to_valid", n_valid, 0);
    clr_counts();
    drive(frame(8'h29, 1'b0, 1'b1), 11, 60, -1);
    cyc(20);
    check("to_next_valid", n_valid, 1);
    check("to_next_recv", {24'd0, recv_data}, 32'h29);

    // Glitches in IDLE and mid-DATA must not register as falls.
    clr_counts();
    PS2_CLK = 1'b0;
    cyc(3);
    PS2_CLK = 1'b1;
    cyc(20);
    check("gl_idle_busy", {31'd0, busy}, 0);
    drive(frame(8'h5A, 1'b1, 1'b1), 11, 60, 3);
    cyc(20);
    check("gl_cnt_pre", {29'd0, cnt_pre}, 3);
    check("gl_cnt_post", {29'd0, cnt_post}, 3);
    check("gl_valid", n_valid, 1);
    check("gl_ferr", n_ferr, 0);
    check("gl_recv", {24'd0, recv_data}, 32'h5A);

    // Reset after 4 data bits; the leftover edges form a partial frame.
    clr_counts();
    drive(frame(8'h1C, 1'b0, 1'b1), 5, 60, -1);
    cyc(20);
    nRST = 1'b0;
    #1;
    check("mr_recv", {24'd0, recv_data}, 0);
    check("mr_busy", {31'd0, busy}, 0);
    check("mr_valid", {31'd0, valid_o}, 0);
    cyc(2);
    nRST = 1'b1;
    cyc(5);
    drive(frame(8'h1C, 1'b0, 1'b1) >> 5, 6, 60, -1);
    cyc(20);
    check("mr_tail_valid", n_valid, 0);
    wait_ferr("mr");
    clr_counts();
    drive(frame(8'h1C, 1'b0, 1'b1), 11, 60, -1);
    cyc(20);
    check("mr_next_valid", n_valid, 1);
    check("mr_next_recv", {24'd0, recv_data}, 32'h1C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
